// File: rtl/chip_7400_emulator.sv
// chip_7400_emulator: behavioural 7400 quad 2-input NAND responder.
//
// Each gate's ideal NAND goes through a DELAY-deep pipeline (DELAY legal
// range 1..7). The last stage is the gate's raw output. An input-pair
// coverage map records which {A,B} combinations each gate has seen. A
// Settled flag indicates that the outputs reflect the current pin inputs.
//
// Optional feature macro: CHIP_7400_EMU_FAULT_EN.
//   Defined   - a per-gate 2-bit fault table is built, and its mode is
//               applied to the raw output without extra delay.
//   Undefined - the Fault_* ports are ignored, and outputs are the raw
//               pipeline.
//
// Fault_Load strobe semantics: there is no ready. Fault_Load is sampled at
// every edge where it is high. Each such edge writes Fault_Mode into entry
// Fault_Gate, and the new mode is visible on the pins from that edge
// onward. Holding the strobe high repeats the same write.
module chip_7400_emulator #(
  parameter int DELAY = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Pin1,
  input  logic        Pin2,
  output logic        Pin3,
  input  logic        Pin4,
  input  logic        Pin5,
  output logic        Pin6,
  input  logic        Pin10,
  input  logic        Pin9,
  output logic        Pin8,
  input  logic        Pin13,
  input  logic        Pin12,
  output logic        Pin11,
  input  logic        Fault_Load,
  input  logic [1:0]  Fault_Gate,
  input  logic [1:0]  Fault_Mode,
  input  logic        Cov_Clear,
  output logic [15:0] Cov_Map,
  output logic        Cov_Full,
  output logic        Settled
);

  localparam logic [2:0] DLY = 3'(DELAY);

  logic [3:0]  a_in;
  logic [3:0]  b_in;
  logic [3:0]  nand_now;
  logic [3:0]  pipe_q [DELAY];
  logic [3:0]  raw;
  logic [3:0]  y;
  logic [15:0] cov_sample;
  logic [7:0]  in_vec;
  logic [7:0]  in_q;
  logic [2:0]  cnt_q;

  assign a_in     = {Pin13, Pin10, Pin4, Pin1};
  assign b_in     = {Pin12, Pin9,  Pin5, Pin2};
  assign nand_now = ~(a_in & b_in);
  assign in_vec   = {a_in, b_in};
  assign raw      = pipe_q[DELAY-1];

  // Delay pipeline: stage 0 captures the ideal NAND, then shifts toward the output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= 4'hF;
    end else begin
      pipe_q[0] <= nand_now;
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef CHIP_7400_EMU_FAULT_EN
  logic [1:0] fault_q [4];

  // Fault table write; the last write to a gate wins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int g = 0; g < 4; g++) fault_q[g] <= 2'b00;
    end else if (Fault_Load) begin
      fault_q[Fault_Gate] <= Fault_Mode;
    end
  end

  // Fault stage applied to the raw pipeline output, undelayed.
  always_comb begin
    y = raw;
    for (int g = 0; g < 4; g++) begin
      case (fault_q[g])
        2'b01:   y[g] = 1'b0;
        2'b10:   y[g] = 1'b1;
        2'b11:   y[g] = ~raw[g];
        default: y[g] = raw[g];
      endcase
    end
  end
`else
  logic unused_fault;
  assign unused_fault = ^{Fault_Load, Fault_Gate, Fault_Mode};

  // Without the fault table, the outputs are the raw pipeline.
  always_comb begin
    y = raw;
  end
`endif

  assign Pin3  = y[0];
  assign Pin6  = y[1];
  assign Pin8  = y[2];
  assign Pin11 = y[3];

  // One-hot of each gate's current {A,B}, placed in that gate's nibble.
  always_comb begin
    cov_sample = '0;
    for (int g = 0; g < 4; g++) begin
      cov_sample[g*4 +: 4] = 4'b0001 << {a_in[g], b_in[g]};
    end
  end

  // Coverage map accumulation; a clear wins and drops this edge's sample.
  always_ff @(posedge Clk) begin
    if (Reset || Cov_Clear) Cov_Map <= '0;
    else                    Cov_Map <= Cov_Map | cov_sample;
  end

  assign Cov_Full = &Cov_Map;

  // Settled counter. The edge that samples a change counts as the first
  // pipeline stage, so the count reloads to 1 on a change. Settled then
  // rises on the same edge that the change reaches the output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_q  <= '0;
      cnt_q <= '0;
    end else begin
      in_q <= in_vec;
      if (in_vec != in_q)  cnt_q <= 3'd1;
      else if (cnt_q != DLY) cnt_q <= cnt_q + 3'd1;
    end
  end

  assign Settled = (cnt_q == DLY);

endmodule

// File: tb/tb_chip_7400_emulator.sv
// tb_chip_7400_emulator: directed bench for chip_7400_emulator at DELAY=2.
// Expectations for fault behaviour follow CHIP_7400_EMU_FAULT_EN.
module tb_chip_7400_emulator;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Pin1, Pin2, Pin4, Pin5, Pin10, Pin9, Pin13, Pin12;
  logic        Pin3, Pin6, Pin8, Pin11;
  logic        Fault_Load;
  logic [1:0]  Fault_Gate;
  logic [1:0]  Fault_Mode;
  logic        Cov_Clear;
  logic [15:0] Cov_Map;
  logic        Cov_Full;
  logic        Settled;

  int checks = 0;
  int errors = 0;

`ifdef CHIP_7400_EMU_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  chip_7400_emulator #(.DELAY(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3),
    .Pin4(Pin4), .Pin5(Pin5), .Pin6(Pin6),
    .Pin10(Pin10), .Pin9(Pin9), .Pin8(Pin8),
    .Pin13(Pin13), .Pin12(Pin12), .Pin11(Pin11),
    .Fault_Load(Fault_Load), .Fault_Gate(Fault_Gate), .Fault_Mode(Fault_Mode),
    .Cov_Clear(Cov_Clear), .Cov_Map(Cov_Map), .Cov_Full(Cov_Full),
    .Settled(Settled)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Advance one active edge and sample on the following falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Drive {A,B} on every gate. Each argument packs the gate's pair as {A,B}.
  task automatic set_in(input logic [1:0] g0, input logic [1:0] g1,
                        input logic [1:0] g2, input logic [1:0] g3);
    {Pin1, Pin2}   = g0;
    {Pin4, Pin5}   = g1;
    {Pin10, Pin9}  = g2;
    {Pin13, Pin12} = g3;
  endtask

  // Write one fault-table entry with a single-cycle strobe.
  task automatic load_fault(input logic [1:0] gate, input logic [1:0] mode);
    Fault_Load = 1'b1;
    Fault_Gate = gate;
    Fault_Mode = mode;
    tick();
    Fault_Load = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pins();
    return {12'h0, Pin11, Pin8, Pin6, Pin3};
  endfunction

  initial begin
    Reset = 1'b1;
    Fault_Load = 1'b0; Fault_Gate = 2'd0; Fault_Mode = 2'd0; Cov_Clear = 1'b0;
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    @(negedge Clk);
    tick(); tick();
    chk("reset_pins", pins(), 16'h000F);
    chk("reset_cov", Cov_Map, 16'h0000);
    chk("reset_full", {15'h0, Cov_Full}, 16'h0);
    chk("reset_settled", {15'h0, Settled}, 16'h0);

    // All gates to 11 at edge 0.
    Reset = 1'b0;
    set_in(2'b11, 2'b11, 2'b11, 2'b11);
    tick();
    chk("e0_pins", pins(), 16'h000F);
    chk("e0_settled", {15'h0, Settled}, 16'h0);
    chk("e0_cov", Cov_Map, 16'h8888);
    tick();
    chk("e1_pins", pins(), 16'h0000);
    chk("e1_settled", {15'h0, Settled}, 16'h1);

    // Clear, then sweep 00..11 on all gates.
    Cov_Clear = 1'b1;
    tick();
    Cov_Clear = 1'b0;
    chk("clear_cov", Cov_Map, 16'h0000);
    set_in(2'b00, 2'b00, 2'b00, 2'b00); tick();
    chk("sweep00_cov", Cov_Map, 16'h1111);
    set_in(2'b01, 2'b01, 2'b01, 2'b01); tick();
    chk("sweep01_cov", Cov_Map, 16'h3333);
    set_in(2'b10, 2'b10, 2'b10, 2'b10); tick();
    chk("sweep10_cov", Cov_Map, 16'h7777);
    chk("sweep10_full", {15'h0, Cov_Full}, 16'h0);
    set_in(2'b11, 2'b11, 2'b11, 2'b11); tick();
    chk("sweep11_cov", Cov_Map, 16'hFFFF);
    chk("sweep11_full", {15'h0, Cov_Full}, 16'h1);
    Cov_Clear = 1'b1; tick(); Cov_Clear = 1'b0;
    chk("clear2_cov", Cov_Map, 16'h0000);
    chk("clear2_full", {15'h0, Cov_Full}, 16'h0);

    // The first 11 on gate 3 coincides with a clear, so bit 15 is never recorded.
    set_in(2'b00, 2'b00, 2'b00, 2'b11);
    Cov_Clear = 1'b1; tick(); Cov_Clear = 1'b0;
    chk("coincident_cov", Cov_Map, 16'h0000);
    set_in(2'b00, 2'b00, 2'b00, 2'b00); tick();
    chk("after_coincident_cov", Cov_Map, 16'h1111);

    // Gate 2 stuck-1 with all inputs at 11.
    set_in(2'b11, 2'b11, 2'b11, 2'b11); tick(); tick();
    chk("all11_pins", pins(), 16'h0000);
    load_fault(2'd2, 2'b10);
    chk("stuck1_pins", pins(), {12'h0, 1'b0, FEN, 2'b00});
    load_fault(2'd2, 2'b00);
    chk("unfault_pins", pins(), 16'h0000);

    // Two consecutive writes to gate 1: stuck-0, then stuck-1.
    Fault_Load = 1'b1; Fault_Gate = 2'd1; Fault_Mode = 2'b01; tick();
    Fault_Mode = 2'b10; tick(); Fault_Load = 1'b0;
    chk("last_write_pins", pins(), {12'h0, 2'b00, FEN, 1'b0});

    // Gate 0 inverted: 01 then 11.
    load_fault(2'd0, 2'b11);
    set_in(2'b01, 2'b11, 2'b11, 2'b11); tick();
    chk("inv01_settled_early", {15'h0, Settled}, 16'h0);
    tick();
    chk("inv01_settled", {15'h0, Settled}, 16'h1);
    chk("inv01_pin3", {15'h0, Pin3}, {15'h0, ~FEN});
    set_in(2'b11, 2'b11, 2'b11, 2'b11); tick(); tick();
    chk("inv11_pin3", {15'h0, Pin3}, {15'h0, FEN});

    // Reset mid-sweep with faults still loaded.
    set_in(2'b00, 2'b00, 2'b00, 2'b00); tick();
    Reset = 1'b1; Cov_Clear = 1'b0; tick();
    chk("midreset_pins", pins(), 16'h000F);
    chk("midreset_cov", Cov_Map, 16'h0000);
    chk("midreset_settled", {15'h0, Settled}, 16'h0);
    Reset = 1'b0;
    set_in(2'b11, 2'b11, 2'b11, 2'b11); tick();
    chk("post_reset_e0_pins", pins(), 16'h000F);
    chk("post_reset_e0_settled", {15'h0, Settled}, 16'h0);
    tick();
    chk("post_reset_nand", pins(), 16'h0000);
    chk("post_reset_settled", {15'h0, Settled}, 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
